// File: rtl/sar_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// sar_scan_sequencer_if
//   Groups the ADC handshake and the result bus of the SAR scan sequencer.
//
//   Handshake: the sequencer pulses ADC_GO high for exactly one CLK cycle to
//   start a conversion on the channel shown on MUX_SEL. The SAR logic reports
//   completion with a 0->1 edge on ADC_VALID, with ADC_RESULT stable while
//   ADC_VALID is high. On the result side, RES_STB is a one-cycle strobe and
//   RES_DATA/RES_CH are valid during it and hold until the next strobe. There
//   is no backpressure on either side.
//
//   Signals:
//     ADC_GO      sequencer -> SAR   conversion start pulse
//     ADC_VALID   SAR -> sequencer   conversion done (level, edge detected)
//     ADC_RESULT  SAR -> sequencer   conversion result, NBITS wide
//     MUX_SEL     sequencer -> mux   analog mux select, CW wide
//     RES_DATA    sequencer -> user  captured result
//     RES_CH      sequencer -> user  channel of the captured result
//     RES_STB     sequencer -> user  result strobe
//
//   Modports: master = sequencer side, slave = SAR/mux/consumer side.
// -----------------------------------------------------------------------------
interface sar_scan_sequencer_if #(
  parameter int NBITS = 8,
  parameter int NCH   = 4
) ();
  localparam int CW = $clog2(NCH);

  logic             ADC_GO;
  logic             ADC_VALID;
  logic [NBITS-1:0] ADC_RESULT;
  logic [CW-1:0]    MUX_SEL;
  logic [NBITS-1:0] RES_DATA;
  logic [CW-1:0]    RES_CH;
  logic             RES_STB;

  modport master (
    output ADC_GO,
    output MUX_SEL,
    output RES_DATA,
    output RES_CH,
    output RES_STB,
    input  ADC_VALID,
    input  ADC_RESULT
  );

  modport slave (
    input  ADC_GO,
    input  MUX_SEL,
    input  RES_DATA,
    input  RES_CH,
    input  RES_STB,
    output ADC_VALID,
    output ADC_RESULT
  );
endinterface

// File: rtl/sar_scan_sequencer.sv
// -----------------------------------------------------------------------------
// sar_scan_sequencer
//   Round-robin scan sequencer for a SAR ADC behind an analog multiplexer.
//   For every enabled channel it selects the mux input, waits SETTLE_CYC
//   cycles, fires a one-cycle ADC_GO, waits for the ADC_VALID rising edge
//   (bounded by TMO_CYC cycles) and publishes the result with a RES_STB pulse.
//
//   Optional feature macro: SARSEQ_AVG_EN
//     defined   : four back-to-back conversions per channel visit, the sum is
//                 accumulated in NBITS+2 bits and RES_DATA = sum >> 2.
//     undefined : one conversion per channel visit, no accumulator.
//
//   Parameters:
//     NBITS      ADC result width
//     NCH        number of analog channels (2..16), CW = clog2(NCH)
//     SETTLE_CYC mux settling cycles before each conversion (1..255)
//     TMO_CYC    max cycles from ADC_GO to ADC_VALID edge (2..1023)
//
//   Ports:
//     CLK         clock
//     RST         asynchronous active-high reset, released synchronously
//     EN          scan enable
//     CH_MASK     per-channel enable, NCH wide
//     BUSY        high in every state except IDLE
//     TMO_ERR     sticky conversion timeout flag (cleared by reset or EN 0->1)
//     o_dbg_state current FSM state encoding
//     bus         master side of sar_scan_sequencer_if (ADC_GO, ADC_VALID,
//                 ADC_RESULT, MUX_SEL, RES_DATA, RES_CH, RES_STB)
// -----------------------------------------------------------------------------
module sar_scan_sequencer #(
  parameter int NBITS      = 8,
  parameter int NCH        = 4,
  parameter int SETTLE_CYC = 4,
  parameter int TMO_CYC    = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NCH-1:0]       CH_MASK,
  output logic                 BUSY,
  output logic                 TMO_ERR,
  output logic [2:0]           o_dbg_state,
  sar_scan_sequencer_if.master bus
);

  localparam int CW = $clog2(NCH);

  // Settle counter is loaded with SETTLE_CYC-1 and counts down to zero, so the
  // SETTLE state lasts exactly SETTLE_CYC cycles.
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  // The timeout counter starts at 0 on the first WAIT cycle (cleared in
  // START). The limit TMO_CYC-2 makes TMO_ERR rise exactly TMO_CYC cycles
  // after the clock edge that raised ADC_GO.
  localparam logic [9:0] TMO_LIM   = 10'(TMO_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_ptr;
  logic [CW-1:0]    r_mux_sel;
  logic [7:0]       r_settle_cnt;
  logic [9:0]       r_tmo_cnt;
  logic             r_valid_q;
  logic             r_en_q;
  logic [NBITS-1:0] r_res_data;
  logic [CW-1:0]    r_res_ch;
  logic             r_tmo_err;

`ifdef SARSEQ_AVG_EN
  logic [NBITS+1:0] r_acc;
  logic [1:0]       r_conv_idx;
  logic [NBITS+1:0] w_sum;
`endif

  logic [CW-1:0]    w_ptr_inc;
  logic [CW-1:0]    w_srch_start;
  logic [CW:0]      w_srch;
  logic             w_found;
  logic [CW-1:0]    w_srch_ch;
  logic             w_valid_rise;
  logic             w_sel_load;
  logic             w_timeout;
  logic             w_decide;

  // Lowest enabled channel at or above 'start', wrapping past NCH-1 to 0.
  // Returns {found, channel}. Iterating from the farthest offset down lets the
  // nearest hit overwrite earlier ones, which keeps the loop priority-free.
  function automatic logic [CW:0] f_next_ch(input logic [NCH-1:0] mask,
                                            input logic [CW-1:0]  start);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (mask[idx[CW-1:0]]) res = {1'b1, idx[CW-1:0]};
    end
    return res;
  endfunction

  // Pointer after a finished channel: MUX_SEL + 1 modulo NCH.
  assign w_ptr_inc    = (r_mux_sel == CW'(NCH - 1)) ? '0 : r_mux_sel + CW'(1);
  // From IDLE the search starts at the stored pointer; at the end of a
  // conversion it starts at the channel after the one just finished.
  assign w_srch_start = (r_state == S_IDLE) ? r_ptr : w_ptr_inc;
  assign w_srch       = f_next_ch(CH_MASK, w_srch_start);
  assign w_found      = w_srch[CW];
  assign w_srch_ch    = w_srch[CW-1:0];
  assign w_valid_rise = bus.ADC_VALID & ~r_valid_q;

`ifdef SARSEQ_AVG_EN
  assign w_sum = r_acc + {2'b00, bus.ADC_RESULT};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_sel_load  = 1'b0;
    w_timeout   = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EN && w_found) begin
          w_state_nxt = S_SETTLE;
          w_sel_load  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == 8'd0) w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_valid_rise) begin
`ifdef SARSEQ_AVG_EN
          // Repeat START/WAIT without re-settling until four samples are in.
          if (r_conv_idx == 2'd3) w_state_nxt = S_CAPTURE;
          else                    w_state_nxt = S_START;
`else
          w_state_nxt = S_CAPTURE;
`endif
        end else if (r_tmo_cnt >= TMO_LIM) begin
          // Timeout: no result for this channel, move on.
          w_timeout = 1'b1;
          w_decide  = 1'b1;
          if (EN && w_found) begin
            w_state_nxt = S_SETTLE;
            w_sel_load  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_CAPTURE: begin
        w_decide = 1'b1;
        if (EN && w_found) begin
          w_state_nxt = S_SETTLE;
          w_sel_load  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the registered state, so reset drops them at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ADC_GO   = (r_state == S_START);
    bus.RES_STB  = (r_state == S_CAPTURE);
    BUSY         = (r_state != S_IDLE);
    bus.MUX_SEL  = r_mux_sel;
    bus.RES_DATA = r_res_data;
    bus.RES_CH   = r_res_ch;
    TMO_ERR      = r_tmo_err;
    o_dbg_state  = r_state;
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel pointer, counters, result capture, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr        <= '0;
      r_mux_sel    <= '0;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_valid_q    <= 1'b0;
      r_en_q       <= 1'b0;
      r_res_data   <= '0;
      r_res_ch     <= '0;
      r_tmo_err    <= 1'b0;
`ifdef SARSEQ_AVG_EN
      r_acc        <= '0;
      r_conv_idx   <= '0;
`endif
    end else begin
      r_valid_q <= bus.ADC_VALID;
      r_en_q    <= EN;

      if (w_decide) r_ptr <= w_ptr_inc;

      // New channel visit: select it, arm the settle counter.
      if (w_sel_load) begin
        r_mux_sel    <= w_srch_ch;
        r_settle_cnt <= SETTLE_LD;
`ifdef SARSEQ_AVG_EN
        r_acc        <= '0;
        r_conv_idx   <= '0;
`endif
      end else if ((r_state == S_SETTLE) && (r_settle_cnt != 8'd0)) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end

      // Timeout counter saturates at all-ones instead of wrapping.
      if (r_state == S_START) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 10'd1;
      end

      // Result is registered on the edge that enters CAPTURE so that
      // RES_DATA/RES_CH are already valid while RES_STB is high.
      if ((r_state == S_WAIT) && w_valid_rise) begin
`ifdef SARSEQ_AVG_EN
        if (r_conv_idx == 2'd3) begin
          r_res_data <= w_sum[NBITS+1:2];
          r_res_ch   <= r_mux_sel;
        end else begin
          r_acc      <= w_sum;
          r_conv_idx <= r_conv_idx + 2'd1;
        end
`else
        r_res_data <= bus.ADC_RESULT;
        r_res_ch   <= r_mux_sel;
`endif
      end

      // Sticky error: a fresh EN assertion clears it, a timeout in the same
      // cycle still wins so no error is lost.
      if (EN && !r_en_q) r_tmo_err <= 1'b0;
      if (w_timeout)     r_tmo_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sar_scan_sequencer
//   Directed bench for sar_scan_sequencer with a behavioural SAR model that
//   answers each ADC_GO with a VALID edge 10 cycles later (result 8'h40+ch, or
//   a table of values), and can be told never to answer on one channel.
// -----------------------------------------------------------------------------
module tb_sar_scan_sequencer;

  localparam int NBITS      = 8;
  localparam int NCH        = 4;
  localparam int SETTLE_CYC = 4;
  localparam int TMO_CYC    = 64;

`ifdef SARSEQ_AVG_EN
  // SETTLE + 4 x (START + 10 WAIT) + CAPTURE
  localparam int VISIT_CYC = 49;
`else
  // SETTLE + START + 10 WAIT + CAPTURE
  localparam int VISIT_CYC = 16;
`endif

  // ---------------- clock / reset ----------------
  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           EN = 1'b0;
  logic [NCH-1:0] CH_MASK = '0;
  logic           BUSY;
  logic           TMO_ERR;
  logic [2:0]     dbg_state;

  always #5 CLK = ~CLK;

  sar_scan_sequencer_if #(.NBITS(NBITS), .NCH(NCH)) bus ();

  sar_scan_sequencer #(
    .NBITS(NBITS), .NCH(NCH), .SETTLE_CYC(SETTLE_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_MASK(CH_MASK),
    .BUSY(BUSY), .TMO_ERR(TMO_ERR), .o_dbg_state(dbg_state), .bus(bus)
  );

  // ---------------- SAR model ----------------
  logic             adc_valid  = 1'b0;
  logic [NBITS-1:0] adc_result = '0;
  logic [NBITS-1:0] adc_val    = '0;
  int               adc_cnt    = 0;
  int               adc_hold   = 0;
  int               dead_ch    = -1;
  bit               use_tab    = 1'b0;
  int               tab_idx    = 0;
  logic [NBITS-1:0] tab [4]    = '{8'd10, 8'd11, 8'd12, 8'd14};

  assign bus.ADC_VALID  = adc_valid;
  assign bus.ADC_RESULT = adc_result;

  always @(negedge CLK) begin
    if (adc_hold > 0) begin
      adc_hold = adc_hold - 1;
      if (adc_hold == 0) adc_valid = 1'b0;
    end
    if (bus.ADC_GO) begin
      if (int'(bus.MUX_SEL) != dead_ch) begin
        adc_cnt = 10;
        adc_val = use_tab ? tab[tab_idx % 4] : 8'h40 + 8'(bus.MUX_SEL);
        tab_idx = tab_idx + 1;
      end
    end else if (adc_cnt > 0) begin
      adc_cnt = adc_cnt - 1;
      if (adc_cnt == 0) begin
        adc_valid  = 1'b1;
        adc_result = adc_val;
        adc_hold   = 2;
      end
    end
  end

  // ---------------- monitor ----------------
  int             cyc = 0;
  int             stb_count = 0;
  int             go_count = 0;
  int             busy_count = 0;
  int             mux_chg_cyc = 0;
  int             last_gap = -1;
  bit             gap_pend = 1'b0;
  logic [1:0]     prev_mux = '0;

  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (bus.RES_STB) stb_count = stb_count + 1;
    if (BUSY) busy_count = busy_count + 1;
    if (bus.ADC_GO) begin
      go_count = go_count + 1;
      if (gap_pend) begin
        last_gap = cyc - mux_chg_cyc;
        gap_pend = 1'b0;
      end
    end
    if (bus.MUX_SEL != prev_mux) begin
      mux_chg_cyc = cyc;
      gap_pend    = 1'b1;
      prev_mux    = bus.MUX_SEL;
    end
  end

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [NBITS-1:0] exp_q[$];
  logic [1:0]       exp_ch_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    assert (obs === exp_v) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver / wait tasks ----------------
  task automatic wait_stb(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (bus.RES_STB) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_go(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (bus.ADC_GO) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_tmo(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (TMO_ERR) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (!BUSY) begin got = 1'b1; break; end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit               got;
    int               t0;
    int               t1;
    int               s0;
    int               g0;
    int               b0;
    logic [NBITS-1:0] ev;
    logic [1:0]       ech;

    // Reset values while RST is held
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_busy",     BUSY, 0);
    chk("rst_go",       bus.ADC_GO, 0);
    chk("rst_mux",      bus.MUX_SEL, 0);
    chk("rst_res_data", bus.RES_DATA, 0);
    chk("rst_res_ch",   bus.RES_CH, 0);
    chk("rst_res_stb",  bus.RES_STB, 0);
    chk("rst_tmo",      TMO_ERR, 0);
    chk("rst_state",    dbg_state, 0);
    RST = 1'b0;

    // Enabled with empty mask: nothing happens
    EN = 1'b1;
    b0 = busy_count;
    g0 = go_count;
    repeat (200) @(negedge CLK);
    chk("nomask_busy", busy_count - b0, 0);
    chk("nomask_go",   go_count - g0, 0);

    // Mask 1010: ch1, ch3, ch1, ch3 with settle gap before each GO
    CH_MASK = 4'b1010;
    exp_q    = '{8'h41, 8'h43, 8'h41, 8'h43};
    exp_ch_q = '{2'd1, 2'd3, 2'd1, 2'd3};
    while (exp_q.size() > 0) begin
      wait_stb(120, got);
      chk("scan_stb_seen", got, 1);
      ev  = exp_q.pop_front();
      ech = exp_ch_q.pop_front();
      chk("scan_res_data", bus.RES_DATA, ev);
      chk("scan_res_ch",   bus.RES_CH, ech);
      chk("scan_settle_gap", last_gap, SETTLE_CYC);
      if (exp_q.size() == 0) EN = 1'b0;
    end
    @(negedge CLK);
    chk("scan_stop_busy", BUSY, 0);
    chk("scan_stop_mux",  bus.MUX_SEL, 3);

    // Single channel: back-to-back visits of ch0
    CH_MASK = 4'b0001;
    EN = 1'b1;
    wait_stb(150, got);
    chk("single_stb1_seen", got, 1);
    chk("single_res_ch1",   bus.RES_CH, 0);
    chk("single_res_data1", bus.RES_DATA, 8'h40);
    t0 = cyc;
    wait_stb(150, got);
    chk("single_stb2_seen", got, 1);
    chk("single_res_ch2",   bus.RES_CH, 0);
    chk("single_period",    cyc - t0, VISIT_CYC);

    // EN dropped 3 cycles after GO on ch0: result still delivered
    wait_go(80, got);
    chk("endrop_go_seen", got, 1);
    repeat (3) @(negedge CLK);
    EN = 1'b0;
    wait_stb(150, got);
    chk("endrop_stb_seen", got, 1);
    chk("endrop_res_ch",   bus.RES_CH, 0);
    chk("endrop_res_data", bus.RES_DATA, 8'h40);
    @(negedge CLK);
    chk("endrop_busy", BUSY, 0);
    chk("endrop_mux",  bus.MUX_SEL, 0);

    // Timeout on ch2
    dead_ch = 2;
    CH_MASK = 4'b0100;
    EN = 1'b1;
    wait_go(40, got);
    chk("tmo_go_seen", got, 1);
    chk("tmo_mux", bus.MUX_SEL, 2);
    t0 = cyc;
    s0 = stb_count;
    wait_tmo(120, got);
    chk("tmo_seen",    got, 1);
    chk("tmo_latency", cyc - t0, TMO_CYC);
    t1 = cyc;
    wait_go(40, got);
    chk("tmo_rego_seen", got, 1);
    chk("tmo_rego_gap",  cyc - t1, SETTLE_CYC);
    chk("tmo_no_stb",    stb_count - s0, 0);
    chk("tmo_sticky",    TMO_ERR, 1);
    EN = 1'b0;
    @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    chk("tmo_en_clear", TMO_ERR, 0);
    EN = 1'b0;
    wait_idle(150, got);
    chk("tmo_idle_seen", got, 1);
    dead_ch = -1;

    // Reset in WAIT, late VALID 2 cycles after release
    CH_MASK = 4'b0001;
    EN = 1'b1;
    wait_go(40, got);
    chk("rstw_go_seen", got, 1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    EN  = 1'b0;
    #1;
    chk("rstw_busy_async", BUSY, 0);
    chk("rstw_go_async",   bus.ADC_GO, 0);
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    s0 = stb_count;
    g0 = go_count;
    repeat (20) @(negedge CLK);
    chk("rstw_no_stb",   stb_count - s0, 0);
    chk("rstw_no_go",    go_count - g0, 0);
    chk("rstw_busy",     BUSY, 0);
    chk("rstw_tmo",      TMO_ERR, 0);
    chk("rstw_res_data", bus.RES_DATA, 0);
    chk("rstw_res_ch",   bus.RES_CH, 0);
    chk("rstw_mux",      bus.MUX_SEL, 0);

    // Result table 10,11,12,14 on ch0
    use_tab = 1'b1;
    tab_idx = 0;
    CH_MASK = 4'b0001;
    EN = 1'b1;
`ifdef SARSEQ_AVG_EN
    exp_q = '{8'd11};
`else
    exp_q = '{8'd10, 8'd11, 8'd12, 8'd14};
`endif
    while (exp_q.size() > 0) begin
      wait_stb(150, got);
      chk("tab_stb_seen", got, 1);
      ev = exp_q.pop_front();
      chk("tab_res_data", bus.RES_DATA, ev);
      chk("tab_res_ch",   bus.RES_CH, 0);
      if (exp_q.size() == 0) EN = 1'b0;
    end
    @(negedge CLK);
    chk("tab_busy", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
